mandelbrot_scheduler: RTL and testbench



---
 rtl/mandelbrot_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_mandelbrot_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_scheduler.sv
// mandelbrot_scheduler: ring of LAT pixel slots recirculating through the fixed-latency iteration loop,
// plus the raster frame sequencer. Define MANDELBROT_SCHED_PERF_EN to add perf_busy/perf_park counters.
module mandelbrot_scheduler #(
    parameter int unsigned RESX = 640,
    parameter int unsigned RESY = 480,
    parameter int unsigned LAT  = 8,
    parameter int unsigned IMAX = 256,
    parameter int unsigned IW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    issue_op,
    output logic [10:0]   issue_x,
    output logic [10:0]   issue_y,
    input  logic          esc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [10:0]   out_x,
    output logic [10:0]   out_y,
    output logic [IW-1:0] out_iter
`ifdef MANDELBROT_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_busy,
    output logic [31:0]   perf_park
`endif
);
    localparam int unsigned CW = 11;
    localparam int unsigned HW = $clog2(LAT);
    localparam int unsigned LW = $clog2(LAT + 1);
    localparam logic [1:0]    OP_IDLE = 2'd0;
    localparam logic [1:0]    OP_LOAD = 2'd1;
    localparam logic [1:0]    OP_ITER = 2'd2;
    localparam logic [IW-1:0] IMAX_W  = IW'(IMAX);
    localparam logic [CW-1:0] XLAST   = CW'(RESX - 1);
    localparam logic [CW-1:0] YLAST   = CW'(RESY - 1);
    localparam logic [HW-1:0] HLAST   = HW'(LAT - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;
    typedef enum logic [1:0] {SL_EMPTY, SL_ACTIVE, SL_PARKED} slot_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d, rem_q, rem_d;
    logic [HW-1:0] head_q, head_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [LW-1:0] live_q, live_d;

    slot_e         st_q [LAT];
    logic [CW-1:0] sx_q [LAT];
    logic [CW-1:0] sy_q [LAT];
    logic [IW-1:0] si_q [LAT];

    slot_e         hst_q, hst_d;
    logic [CW-1:0] hx_q, hx_d, hy_q, hy_d;
    logic [IW-1:0] hi_q, hi_d, hi_inc;

    logic          ov_q, ov_d;
    logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [IW-1:0] oi_q, oi_d;

    logic [1:0]    op_c;
    logic [CW-1:0] ix_c, iy_c;
    logic          out_free, freed, load;

    assign hst_q    = st_q[head_q];
    assign hx_q     = sx_q[head_q];
    assign hy_q     = sy_q[head_q];
    assign hi_q     = si_q[head_q];
    assign hi_inc   = hi_q + IW'(1);
    assign out_free = !ov_q || out_ready;

    // Head-slot decision: issue_* is combinational because it depends on esc for the returning slot.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        head_d  = head_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        live_d  = live_q;
        hst_d   = hst_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        hi_d    = hi_q;
        ov_d    = ov_q && !out_ready;
        ox_d    = ox_q;
        oy_d    = oy_q;
        oi_d    = oi_q;
        op_c    = OP_IDLE;
        ix_c    = '0;
        iy_c    = '0;
        freed   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    rem_d   = 1'b1;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            S_RUN: begin
                head_d = (head_q == HLAST) ? '0 : head_q + HW'(1);
                case (hst_q)
                    SL_ACTIVE: begin
                        if (!esc && hi_inc != IMAX_W) begin
                            hi_d = hi_inc;
                            op_c = OP_ITER;
                        end else if (out_free) begin
                            ov_d  = 1'b1;
                            ox_d  = hx_q;
                            oy_d  = hy_q;
                            oi_d  = hi_inc;
                            freed = 1'b1;
                        end else begin
                            hst_d = SL_PARKED;
                            hi_d  = hi_inc;
                        end
                    end
                    SL_PARKED: begin
                        if (out_free) begin
                            ov_d  = 1'b1;
                            ox_d  = hx_q;
                            oy_d  = hy_q;
                            oi_d  = hi_q;
                            freed = 1'b1;
                        end
                    end
                    default: freed = 1'b1;
                endcase
                // A freed slot is refilled from the raster counter in the same cycle.
                if (freed) begin
                    hst_d = SL_EMPTY;
                    if (rem_q) begin
                        load  = 1'b1;
                        hst_d = SL_ACTIVE;
                        hx_d  = cx_q;
                        hy_d  = cy_q;
                        hi_d  = '0;
                        op_c  = OP_LOAD;
                        ix_c  = cx_q;
                        iy_c  = cy_q;
                        if (cx_q == XLAST) begin
                            cx_d = '0;
                            if (cy_q == YLAST) rem_d = 1'b0;
                            else               cy_d  = cy_q + CW'(1);
                        end else begin
                            cx_d = cx_q + CW'(1);
                        end
                    end
                end
                if (load && hst_q == SL_EMPTY)                   live_d = live_q + LW'(1);
                else if (!load && freed && hst_q != SL_EMPTY)    live_d = live_q - LW'(1);
                if (!rem_d && live_d == '0 && !ov_d) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    head_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= 1'b0;
            head_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            live_q  <= '0;
            ov_q    <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            oi_q    <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                st_q[i] <= SL_EMPTY;
                sx_q[i] <= '0;
                sy_q[i] <= '0;
                si_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            live_q  <= live_d;
            ov_q    <= ov_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            oi_q    <= oi_d;
            if (state_q == S_RUN) begin
                st_q[head_q] <= hst_d;
                sx_q[head_q] <= hx_d;
                sy_q[head_q] <= hy_d;
                si_q[head_q] <= hi_d;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign issue_op  = op_c;
    assign issue_x   = ix_c;
    assign issue_y   = iy_c;
    assign out_valid = ov_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign out_iter  = oi_q;

`ifdef MANDELBROT_SCHED_PERF_EN
    logic [31:0] pb_q, pp_q;
    logic        start_acc;

    assign start_acc = (state_q == S_IDLE) && start && !done_q;

    // Saturating activity counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_q <= '0;
            pp_q <= '0;
        end else if (start_acc) begin
            pb_q <= '0;
            pp_q <= '0;
        end else begin
            if (busy_q && pb_q != '1)                       pb_q <= pb_q + 32'd1;
            if (busy_q && hst_q == SL_PARKED && pp_q != '1) pp_q <= pp_q + 32'd1;
        end
    end

    assign perf_busy = pb_q;
    assign perf_park = pp_q;
`endif

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Bench for mandelbrot_scheduler: models the iteration loop as a LAT-deep delay line with per-pixel
// escape passes, and scoreboards retired pixels against min(escape pass, IMAX).
module tb_mandelbrot_scheduler;
    localparam int RESX = 4;
    localparam int RESY = 2;
    localparam int LAT  = 4;
    localparam int IMAX = 8;
    localparam int IW   = 16;
    localparam int NPIX = RESX * RESY;
    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_ITER = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done, esc, out_valid, out_ready;
    logic [1:0]    issue_op;
    logic [10:0]   issue_x, issue_y, out_x, out_y;
    logic [IW-1:0] out_iter;
`ifdef MANDELBROT_SCHED_PERF_EN
    logic [31:0]   perf_busy, perf_park;
`endif

    always #5 clk = ~clk;

    mandelbrot_scheduler #(.RESX(RESX), .RESY(RESY), .LAT(LAT), .IMAX(IMAX), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .issue_op(issue_op), .issue_x(issue_x), .issue_y(issue_y), .esc(esc),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_iter(out_iter)
`ifdef MANDELBROT_SCHED_PERF_EN
        , .perf_busy(perf_busy), .perf_park(perf_park)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int e_at [NPIX];
    int passes [NPIX];
    int r_op [LAT];
    int r_pix [LAT];
    int exp_pix [$];
    int exp_it [$];
    int op_hist [int];
    int rdy_mode = 1;
    int rdy_pct = 100;
    int raster_chk = 0;
    int out_seq = 0;
    int nx_pix = 0;
    int start_cyc = 0;
    int first_ov_cyc = -1;
    int last_load_cyc = 0;
    int last_hs_cyc = 0;
    int n_done = 0;
    int n_acc = 0;
    int busy_cnt = 0;
    int exp_done = 0;
    bit frame_open = 0;
    bit hold_pend = 0;
    longint hold_val = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Loop model and monitor: drives esc/out_ready just after the edge, samples at the falling edge.
    initial begin : monitor
        int idx, p, k;
        bit ret_act, fin_m;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rdy_mode == 2) out_ready = ($urandom_range(0, 99) < rdy_pct);
            else               out_ready = (rdy_mode == 1);
            idx = cyc % LAT;
            ret_act = (r_op[idx] != OP_IDLE);
            fin_m = 1'b0;
            if (ret_act) begin
                p = r_pix[idx];
                passes[p]++;
                esc = (passes[p] >= e_at[p]);
                fin_m = esc || (passes[p] >= IMAX);
            end else begin
                esc = 1'($urandom);
            end
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ctl", {busy, done, issue_op, out_valid}, 0);
                chk("rst_data", {issue_x, issue_y, out_x, out_y, out_iter}, 0);
                for (int i = 0; i < LAT; i++) r_op[i] = OP_IDLE;
                frame_open = 1'b0;
                hold_pend = 1'b0;
                continue;
            end
            op_hist[cyc] = issue_op;
            if (start && !busy && !done) begin
                n_acc++;
                frame_open = 1'b1;
                start_cyc = cyc;
                first_ov_cyc = -1;
                nx_pix = 0;
                out_seq = 0;
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
            if (ret_act) chk("iter_decision", issue_op == OP_ITER, !fin_m);
            case (issue_op)
                OP_LOAD: begin
                    chk("load_x", issue_x, nx_pix % RESX);
                    chk("load_y", issue_y, nx_pix / RESX);
                    p = int'(issue_y) * RESX + int'(issue_x);
                    if (issue_x < RESX && issue_y < RESY) begin
                        passes[p] = 0;
                        r_op[idx] = OP_LOAD;
                        r_pix[idx] = p;
                    end else begin
                        r_op[idx] = OP_IDLE;
                    end
                    nx_pix++;
                    last_load_cyc = cyc;
                end
                OP_ITER: begin
                    if (!ret_act) chk("iter_without_pixel", 1, 0);
                    r_op[idx] = ret_act ? OP_ITER : OP_IDLE;
                end
                OP_IDLE: r_op[idx] = OP_IDLE;
                default: begin
                    chk("op_code", issue_op, 0);
                    r_op[idx] = OP_IDLE;
                end
            endcase
            if (issue_op != OP_LOAD) chk("issue_xy_zero", {issue_x, issue_y}, 0);
            if (hold_pend) chk("out_hold", {out_valid, out_x, out_y, out_iter}, hold_val);
            hold_pend = out_valid && !out_ready;
            hold_val = {out_valid, out_x, out_y, out_iter};
            if (out_valid && first_ov_cyc < 0 && frame_open) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
                k = -1;
                p = int'(out_y) * RESX + int'(out_x);
                foreach (exp_pix[i]) if (out_x < RESX && exp_pix[i] == p) k = i;
                if (k < 0) begin
                    chk("retire_known_unique", 0, 1);
                end else begin
                    chk("out_iter", out_iter, exp_it[k]);
                    exp_pix.delete(k);
                    exp_it.delete(k);
                end
                if (raster_chk != 0) chk("raster_out", p, out_seq);
                out_seq++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                n_done++;
                chk("done_lat", cyc - last_hs_cyc, 1);
                chk("done_frame_open", frame_open, 1);
                chk("done_busy", busy, 0);
                chk("done_drained", exp_pix.size(), 0);
                frame_open = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode 0: escape at pass 1; mode 1: never escapes; mode 2: random escape pass.
    task automatic setup_frame(input int mode);
        exp_pix.delete();
        exp_it.delete();
        for (int p = 0; p < NPIX; p++) begin
            e_at[p] = (mode == 0) ? 1 : (mode == 1) ? IMAX + 5 : int'($urandom_range(1, IMAX + 2));
            exp_pix.push_back(p);
            exp_it.push_back(e_at[p] < IMAX ? e_at[p] : IMAX);
        end
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        bit ok;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        else     exp_done++;
    endtask

    initial begin : stim
        int cnt;
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        esc = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Escape on first pass: raster-order retirement, all out_iter=1.
        setup_frame(0);
        raster_chk = 1;
        rdy_mode = 1;
        pulse_start();
        wait_done(200);
        raster_chk = 0;
        chk("A_count", out_seq, NPIX);

        // Never escapes: every pixel runs IMAX passes.
        setup_frame(1);
        pulse_start();
        wait_done(400);
        chk("B_first_ov", first_ov_cyc - start_cyc, 1 + LAT * IMAX + 1);
        for (int k = 1; k <= LAT; k++) chk("B_load_run", op_hist[start_cyc + k], OP_LOAD);
        chk("B_first_iter", op_hist[start_cyc + LAT + 1], OP_ITER);

        // Consumer stalled for 100 cycles: head pixel held, others park.
        setup_frame(1);
        rdy_mode = 0;
        pulse_start();
        repeat (99) tick();
        chk("C_last_load", last_load_cyc - start_cyc, 1 + LAT * IMAX);
        chk("C_held_head", {out_valid, out_x, out_y, out_iter}, {1'b1, 11'd0, 11'd0, 16'(IMAX)});
        chk("C_nothing_retired", exp_pix.size(), NPIX);
        cnt = 0;
        for (int c = start_cyc + 70; c < start_cyc + 100; c++) if (op_hist[c] != OP_IDLE) cnt++;
        chk("C_idle_while_parked", cnt, 0);
        rdy_mode = 1;
        wait_done(400);
        chk("C_all_retired", out_seq, NPIX);
`ifdef MANDELBROT_SCHED_PERF_EN
        chk("C_perf_park_nz", perf_park > 0, 1);
        chk("C_perf_busy", perf_busy, busy_cnt);
`endif

        // start while busy and in the done cycle is ignored.
        setup_frame(2);
        rdy_mode = 2;
        rdy_pct = 60;
        pulse_start();
`ifdef MANDELBROT_SCHED_PERF_EN
        chk("D_perf_clear", {perf_busy, perf_park}, 0);
`endif
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                start = 1'b1;
                tick();
                start = 1'b0;
                break;
            end
        end
        if (!seen) chk("D_done_timeout", 0, 1);
        else       exp_done++;
        repeat (5) tick();
        chk("D_start_in_done_ignored", busy, 0);

        // Reset mid-frame discards the frame; a later frame is complete.
        setup_frame(2);
        pulse_start();
        repeat (12) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_pix.delete();
        exp_it.delete();
        repeat (4) tick();
        chk("E_idle_after_reset", {busy, done, out_valid}, 0);
        setup_frame(2);
        pulse_start();
        wait_done(600);
        chk("E_full_frame", out_seq, NPIX);

        // Randomized frames with random escape passes and consumer backpressure.
        for (int f = 0; f < 12; f++) begin
            setup_frame(2);
            rdy_pct = int'($urandom_range(20, 100));
            pulse_start();
            wait_done(3000);
            chk("R_count", out_seq, NPIX);
        end

        repeat (5) tick();
        chk("one_done_per_frame", n_done, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
